axi_slave_mem: RTL and testbench

- AXI3-style slave memory model that terminates all five channels of the team's AXI interface bundle. It acts as the DUT-side endpoint that the slave driver/monitor clocking views observe.
- Independent write and read engines, each with one outstanding burst.
- Bursts FIXED/INCR/WRAP, byte strobes, OKAY/SLVERR responses.
- Used as the synthesizable target for master-VIP bring-up and as a reference endpoint for the scoreboard.

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_burst_addr.sv | 60 ++++++
 rtl/axi_slave_mem.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared types and helpers for the AXI slave memory model
// Purpose: burst/response encodings, FSM state enums and default width helpers
//          imported by axi_burst_addr and axi_slave_mem.
// Ports:   none (package).
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // Bytes per beat and its log2 for the default 32-bit data path.
  localparam int NB     = 4;
  localparam int LOG2NB = $clog2(NB);

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - combinational next-beat address and burst legality
// Purpose: given the current beat address and the burst attributes, produce the
//          address of the following beat and flag bursts the slave cannot serve.
// Ports:
//   addr      in  ADDR_W  current beat byte address
//   size      in  3       log2 of bytes per beat
//   len       in  4       beats minus one
//   burst     in  2       FIXED / INCR / WRAP (2'b11 reserved)
//   next_addr out ADDR_W  address of the next beat
//   illegal   out 1       size wider than the bus, reserved burst, or bad WRAP length
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int SIZE_MAX = LOG2NB
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_addr;
  logic [2:0]        wrap_sh;
  logic              wrap_len_ok;

  always_comb begin
    bytes       = ADDR_W'(1) << size;
    wrap_len_ok = 1'b1;
    // span = bytes * (len + 1); only power-of-two lengths are legal for WRAP
    case (len)
      4'd1:    wrap_sh = 3'd1;
      4'd3:    wrap_sh = 3'd2;
      4'd7:    wrap_sh = 3'd3;
      4'd15:   wrap_sh = 3'd4;
      default: begin
        wrap_sh     = 3'd0;
        wrap_len_ok = 1'b0;
      end
    endcase
    span      = bytes << wrap_sh;
    incr_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
    wrap_addr = (addr & ~(span - ADDR_W'(1))) | ((addr + bytes) & (span - ADDR_W'(1)));

    illegal = (int'(size) > SIZE_MAX) || (burst == 2'b11) ||
              ((burst == WRAP) && !wrap_len_ok);

    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = wrap_addr;
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3-style slave memory with independent write/read engines
// Purpose: terminates AW/W/B/AR/R with one outstanding burst per direction,
//          FIXED/INCR/WRAP bursts, byte strobes and OKAY/SLVERR responses.
// Build option: define AXI_SLAVE_ADDR_CHECK_EN to flag beats at or beyond
//          MEM_DEPTH*NB bytes as SLVERR; otherwise the word index wraps.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   aw{id,addr,len,size,burst,valid,ready} write address channel
//   w{id,data,strb,last,valid,ready}       write data channel
//   b{id,resp,valid,ready}                 write response channel
//   ar{id,addr,len,size,burst,valid,ready} read address channel
//   r{id,data,resp,last,valid,ready}       read data channel
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8 * NB,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);

`ifdef AXI_SLAVE_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return ADDR_CHECK && ((a >> (BYTE_SH + IDX_W)) != '0);
  endfunction

  // ---------------------------------------------------------------- write
  wstate_e           w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [3:0]        aw_len_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;
  logic [3:0]        w_cnt_q;
  logic              w_err_q;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_illegal;
  logic              w_final;
  logic              w_hs;
  logic              w_addr_err;
  logic              w_beat_err;
  logic              w_commit;
  logic [IDX_W-1:0]  w_idx;

  axi_burst_addr #(.ADDR_W(ADDR_W), .SIZE_MAX(BYTE_SH)) u_waddr (
    .addr     (aw_addr_q),
    .size     (aw_size_q),
    .len      (aw_len_q),
    .burst    (aw_burst_q),
    .next_addr(w_next_addr),
    .illegal  (w_illegal)
  );

  assign w_final    = (w_cnt_q == aw_len_q);
  assign w_hs       = wvalid && wready;
  assign w_addr_err = out_of_range(aw_addr_q);
  // wlast is only checked, never trusted: the burst always runs awlen+1 beats.
  assign w_beat_err = (wid != aw_id_q) || (wlast != w_final) || w_illegal || w_addr_err;
  assign w_commit   = w_hs && !w_illegal && !w_addr_err;
  assign w_idx      = aw_addr_q[BYTE_SH +: IDX_W];

  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    if (!rst) begin
      case (w_state_q)
        W_IDLE: begin
          awready = 1'b1;
          if (awvalid) w_state_d = W_DATA;
        end
        W_DATA: begin
          wready = 1'b1;
          if (wvalid && w_final) w_state_d = W_RESP;
        end
        W_RESP: begin
          bvalid = 1'b1;
          if (bready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
    end else if (awvalid && awready) begin
      aw_id_q    <= awid;
      aw_addr_q  <= awaddr;
      aw_len_q   <= awlen;
      aw_size_q  <= awsize;
      aw_burst_q <= awburst;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else if (w_hs) begin
      w_cnt_q   <= w_cnt_q + 4'd1;
      aw_addr_q <= w_next_addr;
      if (w_beat_err) w_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign bid   = bvalid ? aw_id_q : '0;
  assign bresp = (bvalid && w_err_q) ? 2'(SLVERR) : 2'(OKAY);

  // ----------------------------------------------------------------- read
  rstate_e           r_state_q, r_state_d;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [3:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic [3:0]        r_cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              r_idle;
  logic [ADDR_W-1:0] r_ba_addr;
  logic [2:0]        r_ba_size;
  logic [3:0]        r_ba_len;
  logic [1:0]        r_ba_burst;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_illegal;
  logic              r_last_beat;
  logic              ar_hs;
  logic              r_hs;
  logic              r_load;
  logic [ADDR_W-1:0] r_load_addr;
  logic              r_load_bad;

  // While idle the checker looks at the incoming AR fields so the first beat
  // can be fetched on the handshake; afterwards it walks the latched burst.
  assign r_idle     = (r_state_q == R_IDLE);
  assign r_ba_addr  = r_idle ? araddr  : ar_addr_q;
  assign r_ba_size  = r_idle ? arsize  : ar_size_q;
  assign r_ba_len   = r_idle ? arlen   : ar_len_q;
  assign r_ba_burst = r_idle ? arburst : ar_burst_q;

  axi_burst_addr #(.ADDR_W(ADDR_W), .SIZE_MAX(BYTE_SH)) u_raddr (
    .addr     (r_ba_addr),
    .size     (r_ba_size),
    .len      (r_ba_len),
    .burst    (r_ba_burst),
    .next_addr(r_next_addr),
    .illegal  (r_illegal)
  );

  assign r_last_beat = (r_cnt_q == ar_len_q);
  assign ar_hs       = arvalid && arready;
  assign r_hs        = rvalid && rready;
  assign r_load      = ar_hs || (r_hs && !r_last_beat);
  assign r_load_addr = r_idle ? araddr : r_next_addr;
  assign r_load_bad  = r_illegal || out_of_range(r_load_addr);

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    if (!rst) begin
      case (r_state_q)
        R_IDLE: begin
          arready = 1'b1;
          if (arvalid) r_state_d = R_DATA;
        end
        R_DATA: begin
          rvalid = 1'b1;
          if (rready && r_last_beat) r_state_d = R_IDLE;
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  // mem is read here with a non-blocking load, so a same-cycle write to the
  // same word is not yet visible: the read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_q <= '0;
      rdata_q <= '0;
      rresp_q <= 2'(OKAY);
    end else begin
      if (ar_hs) begin
        ar_id_q    <= arid;
        ar_addr_q  <= araddr;
        ar_len_q   <= arlen;
        ar_size_q  <= arsize;
        ar_burst_q <= arburst;
        r_cnt_q    <= '0;
      end else if (r_hs) begin
        r_cnt_q   <= r_cnt_q + 4'd1;
        ar_addr_q <= r_next_addr;
      end
      if (r_load) begin
        rdata_q <= r_load_bad ? '0 : mem[r_load_addr[BYTE_SH +: IDX_W]];
        rresp_q <= r_load_bad ? 2'(SLVERR) : 2'(OKAY);
      end
    end
  end

  assign rid   = rvalid ? ar_id_q : '0;
  assign rdata = rvalid ? rdata_q : '0;
  assign rresp = rvalid ? rresp_q : 2'(OKAY);
  assign rlast = rvalid && r_last_beat;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  logic [3:0]  rd_id;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [31:0] exp_d [4];

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wlast_at, input bit bad_wid);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) begin chk("aw_timeout", awready, 1); awvalid = 1'b0; return; end
    tick();
    awvalid = 1'b0;
    chk("aw_busy", awready, 0);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wid    = bad_wid ? ~id : id;
      wdata  = wd[i];
      wstrb  = ws[i];
      wlast  = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) begin chk("w_timeout", wready, 1); wvalid = 1'b0; return; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) begin chk("b_timeout", bvalid, 1); bready = 1'b0; return; end
    b_id = bid; b_resp = bresp;
    tick();
    bready = 1'b0;
    chk("b_done", bvalid, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input logic [31:0] stall_exp);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin chk("ar_timeout", arready, 1); arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      if (!rvalid) begin chk("r_timeout", rvalid, 1); rready = 1'b0; return; end
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("stall_rdata", rdata, stall_exp);
          chk("stall_rlast", rlast, 0);
        end
        rready = 1'b1;
      end
      rd_d[i] = rdata; rd_r[i] = rresp; rd_l[i] = rlast; rd_id = rid;
      tick();
    end
    rready = 1'b0;
    chk("r_end_rvalid", rvalid, 0);
  endtask

  task automatic fill_strb(input logic [3:0] s);
    for (int i = 0; i < 16; i++) ws[i] = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    rst = 1'b0;
    tick();
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);

    // INCR write then read back
    fill_strb(4'hF);
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    do_write(4'd3, 32'h10, 4'd3, 3'd2, 2'b01, -1, 1'b0);
    chk("t1_bresp", b_resp, 2'b00);
    chk("t1_bid", b_id, 4'd3);
    do_read(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, -1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rdata", rd_d[i], 32'hA0 + i);
      chk("t1_rresp", rd_r[i], 2'b00);
      chk("t1_rlast", rd_l[i], (i == 3));
    end
    chk("t1_rid", rd_id, 4'd5);

    // WRAP read: 0x18, 0x1C, 0x10, 0x14
    exp_d[0] = 32'hA2; exp_d[1] = 32'hA3; exp_d[2] = 32'hA0; exp_d[3] = 32'hA1;
    do_read(4'd6, 32'h18, 4'd3, 3'd2, 2'b10, -1, 32'h0);
    for (int i = 0; i < 4; i++) chk("t2_wrap", rd_d[i], exp_d[i]);

    // byte-sized INCR inside one word: 0x11 -> 0x12
    do_read(4'd1, 32'h11, 4'd1, 3'd0, 2'b01, -1, 32'h0);
    chk("sz0_b0", rd_d[0], 32'hA0);
    chk("sz0_b1", rd_d[1], 32'hA0);
    chk("sz0_resp", rd_r[1], 2'b00);

    // partial strobes: bytes 0 and 2 replaced
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, -1, 1'b0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, -1, 1'b0);
    chk("t3_bresp", b_resp, 2'b00);
    do_read(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, -1, 32'h0);
    chk("t3_strb", rd_d[0], 32'h11BB33DD);
    chk("t3_rlast", rd_l[0], 1);

    // protocol errors on the write side
    fill_strb(4'hF);
    wd[0] = 32'h80; wd[1] = 32'h81; wd[2] = 32'h82; wd[3] = 32'h83;
    do_write(4'd2, 32'h80, 4'd3, 3'd2, 2'b01, 1, 1'b0);
    chk("t4_early_wlast", b_resp, 2'b10);
    chk("t4_bid", b_id, 4'd2);
    do_write(4'd2, 32'h80, 4'd3, 3'd2, 2'b01, -1, 1'b1);
    chk("t4_bad_wid", b_resp, 2'b10);
    do_write(4'd9, 32'h80, 4'd3, 3'd2, 2'b01, -1, 1'b0);
    chk("t4_recover", b_resp, 2'b00);
    chk("t4_recover_bid", b_id, 4'd9);

    // FIXED burst: last beat wins
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    do_write(4'd4, 32'h60, 4'd2, 3'd2, 2'b00, -1, 1'b0);
    chk("fixed_bresp", b_resp, 2'b00);
    do_read(4'd4, 32'h60, 4'd0, 3'd2, 2'b01, -1, 32'h0);
    chk("fixed_rdata", rd_d[0], 32'h3);

    // illegal write (size wider than bus) is not committed
    wd[0] = 32'hDEADBEEF;
    do_write(4'd7, 32'h40, 4'd0, 3'd3, 2'b01, -1, 1'b0);
    chk("ill_w_bresp", b_resp, 2'b10);
    do_read(4'd7, 32'h40, 4'd0, 3'd2, 2'b01, -1, 32'h0);
    chk("ill_w_keep", rd_d[0], 32'h11BB33DD);
    chk("ill_w_keep_resp", rd_r[0], 2'b00);

    // illegal reads: reserved burst, WRAP with len 2
    do_read(4'd1, 32'h10, 4'd1, 3'd2, 2'b11, -1, 32'h0);
    chk("ill_r_data0", rd_d[0], 32'h0);
    chk("ill_r_resp0", rd_r[0], 2'b10);
    chk("ill_r_resp1", rd_r[1], 2'b10);
    chk("ill_r_last1", rd_l[1], 1);
    do_read(4'd1, 32'h10, 4'd2, 3'd2, 2'b10, -1, 32'h0);
    chk("ill_wrap_resp", rd_r[2], 2'b10);
    chk("ill_wrap_data", rd_d[1], 32'h0);

    // rready stall on beat 2
    do_read(4'd8, 32'h10, 4'd3, 3'd2, 2'b01, 2, 32'hA2);
    chk("t5_b2", rd_d[2], 32'hA2);
    chk("t5_b3", rd_d[3], 32'hA3);
    chk("t5_last", rd_l[3], 1);

    // reset mid read burst
    arid = 4'd2; araddr = 32'h10; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    chk("t5_rst_rvalid_pre", rvalid, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_rvalid", rvalid, 0);
    chk("t5_rst_arready", arready, 0);
    rst = 1'b0; rready = 1'b0;
    tick();
    chk("t5_post_arready", arready, 1);
    chk("t5_post_rvalid", rvalid, 0);
    chk("t5_post_awready", awready, 1);

    // out-of-range address
    wd[0] = 32'hCAFE0000; ws[0] = 4'hF;
    do_write(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, -1, 1'b0);
    do_read(4'd9, 32'h1000, 4'd0, 3'd2, 2'b01, -1, 32'h0);
`ifdef AXI_SLAVE_ADDR_CHECK_EN
    chk("t6_oor_data", rd_d[0], 32'h0);
    chk("t6_oor_resp", rd_r[0], 2'b10);
`else
    chk("t6_wrap_data", rd_d[0], 32'hCAFE0000);
    chk("t6_wrap_resp", rd_r[0], 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
